// File: rtl/serial_para.sv
// -----------------------------------------------------------------------------
// serial_para
//
// Serial-to-parallel deserializer. Collects eight consecutive WIDTH-bit serial
// coefficient words into an eight-lane frame and presents that frame on a held
// output bank with a valid/ready handshake. The first word of a frame lands on
// lane 7 and the eighth on lane 0, matching the team's 8-lane parallel-to-serial
// converter on the transmit side.
//
// When the eighth word arrives while the bank still holds an unconsumed frame,
// the completed frame parks in the collection buffer (pending). in_ready drops
// until the bank can take it, so nothing is ever dropped or overwritten.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset          synchronous active-high reset, overrides every other event
//   input_serial   serial coefficient word
//   in_valid       input_serial carries a word this cycle
//   in_ready       block can accept a word (registered state only)
//   output_para_N  parallel frame lanes 0..7, held between loads
//   out_valid      output bank holds an unconsumed frame
//   out_ready      downstream consumes the frame this cycle
//   fill_count     words in the collection buffer (0..8)
// -----------------------------------------------------------------------------
module serial_para #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_serial,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] output_para_0,
  output logic [WIDTH-1:0] output_para_1,
  output logic [WIDTH-1:0] output_para_2,
  output logic [WIDTH-1:0] output_para_3,
  output logic [WIDTH-1:0] output_para_4,
  output logic [WIDTH-1:0] output_para_5,
  output logic [WIDTH-1:0] output_para_6,
  output logic [WIDTH-1:0] output_para_7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       fill_count
);

  localparam int LANES = 8;

  // Collection buffer. Entries 7..1 are filled by words 0..6 of a frame;
  // entry 0 is only written when the eighth word has to wait for the bank.
  logic [WIDTH-1:0] coll_reg  [LANES];
  logic [WIDTH-1:0] coll_next [LANES];

  // Output bank, one register per lane.
  logic [WIDTH-1:0] bank_reg  [LANES];
  logic [WIDTH-1:0] bank_next [LANES];

  // Frame as it would look if the eighth word goes straight to the bank.
  logic [WIDTH-1:0] frame_direct [LANES];

  logic [2:0] cnt_reg, cnt_next;
  logic       pending_reg, pending_next;
  logic       out_valid_reg, out_valid_next;

  // Handshake terms.
  logic accept;
  logic out_fire;
  logic bank_free;
  logic last_word;
  logic load_direct;   // eighth word plus coll[7:1] go straight to the bank
  logic load_pending;  // parked frame moves from collection buffer to bank
  logic go_pending;    // eighth word arrives but the bank is still occupied
  logic load_any;

  // in_ready depends on the pending register alone, so there is no
  // combinational path from in_valid or out_ready back to in_ready.
  assign in_ready  = !pending_reg;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_reg && out_ready;
  assign bank_free = !out_valid_reg || out_ready;
  assign last_word = (cnt_reg == 3'd7);

  // accept and pending_reg are mutually exclusive, so the two load sources
  // never collide.
  assign load_direct  = accept && last_word && bank_free;
  assign go_pending   = accept && last_word && !bank_free;
  assign load_pending = pending_reg && bank_free;
  assign load_any     = load_direct || load_pending;

  // ---------------------------------------------------------------------------
  // Per-lane next-state logic
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_lane0
        // Lane 0 always receives the eighth word: directly from the input
        // or, if it had to wait, from the dedicated holding register.
        assign frame_direct[gi] = input_serial;
        assign coll_next[gi]    = go_pending ? input_serial : coll_reg[gi];
      end else begin : g_lane_n
        // Word k of a frame (k = 0..6) belongs in collection entry 7-k.
        assign frame_direct[gi] = coll_reg[gi];
        assign coll_next[gi]    = (accept && (cnt_reg == 3'(LANES - 1 - gi)))
                                  ? input_serial : coll_reg[gi];
      end

      // The bank only changes on a load; otherwise it holds, which also
      // keeps it stable while out_valid=1 and out_ready=0.
      assign bank_next[gi] = load_pending ? coll_reg[gi]
                           : load_direct  ? frame_direct[gi]
                           : bank_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_next       = cnt_reg;
    pending_next   = pending_reg;
    out_valid_next = out_valid_reg;

    // Word counter wraps 7 -> 0 naturally on the eighth accept.
    if (accept) begin
      cnt_next = cnt_reg + 3'd1;
    end

    if (go_pending) begin
      pending_next = 1'b1;
    end else if (load_pending) begin
      pending_next = 1'b0;
    end

    // A load in the same cycle as out_fire keeps out_valid high, so the new
    // frame replaces the consumed one without a gap or duplicate.
    if (load_any) begin
      out_valid_next = 1'b1;
    end else if (out_fire) begin
      out_valid_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg       <= 3'd0;
      pending_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        coll_reg[i] <= '0;
        bank_reg[i] <= '0;
      end
    end else begin
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      out_valid_reg <= out_valid_next;
      for (int i = 0; i < LANES; i++) begin
        coll_reg[i] <= coll_next[i];
        bank_reg[i] <= bank_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid  = out_valid_reg;
  assign fill_count = pending_reg ? 4'd8 : {1'b0, cnt_reg};

  assign output_para_0 = bank_reg[0];
  assign output_para_1 = bank_reg[1];
  assign output_para_2 = bank_reg[2];
  assign output_para_3 = bank_reg[3];
  assign output_para_4 = bank_reg[4];
  assign output_para_5 = bank_reg[5];
  assign output_para_6 = bank_reg[6];
  assign output_para_7 = bank_reg[7];

endmodule
